// File: rtl/dmem_responder.sv
// Data-memory slave with byte lanes and a fixed, parameterised access latency.
// Each request is held in registers while the access runs, and an ack pulse marks completion.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [3:0]  dre,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        stall,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: the initiator raises dce and holds it, with stable request
  // fields, until ack is seen. ack pulses exactly one cycle per request.
  // Dropping dce before ack withdraws the request, and nothing is written.
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:2] daddr_r;
  logic [3:0]  we_r;
  logic [3:0]  dre_r;
  logic [31:0] din_r;
  logic [31:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic              complete;
  logic [31:0]       rd_mask;
  logic              unused_addr_bits;

  assign idx              = daddr_r[ADDR_W+1:2];
  assign oor              = |daddr_r[31:ADDR_W+2];
  assign complete         = (state == BUSY) && dce && (cnt == 4'd0);
  assign unused_addr_bits = ^daddr[1:0];

  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < 4; i++) rd_mask[8*i +: 8] = {8{dre_r[i]}};
  end

  assign ack       = (state == DONE);
  assign err       = ack && oor;
  assign stall     = dce && !ack;
  assign fsm_state = state;

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      dout  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dce) begin
            daddr_r <= daddr[31:2];
            we_r    <= we;
            dre_r   <= dre;
            din_r   <= din;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!dce) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Read happens before the lane writes below take effect.
            dout  <= oor ? 32'd0 : (mem[idx] & rd_mask);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset; a reset edge still suppresses the write.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n && complete && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (we_r[i]) mem[idx][8*i +: 8] <= din_r[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: the driver pushes the expected {err, dout}
// for each request, and a monitor pops and checks it on every ack.
module tb_dmem_responder;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int W       = 33;

  logic        clk;
  logic        rst_n;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [3:0]  dre;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        stall;
  logic        err;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .dce        (dce),
    .daddr      (daddr),
    .we         (we),
    .dre        (dre),
    .din        (din),
    .dout       (dout),
    .ack        (ack),
    .stall      (stall),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("stall_rule", 64'(stall), 64'(dce & ~ack));
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(1), 64'(0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("ack_err", 64'(err), 64'(e[32]));
          check("ack_dout", 64'(dout), 64'(e[31:0]));
        end
      end else begin
        check("err_without_ack", 64'(err), 64'(0));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dce = 1'b0;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                        input logic [31:0] d, input logic [31:0] exp_dout, input logic exp_err);
    int cyc;
    int stall_cyc;
    @(posedge clk); #1;
    dce = 1'b1; daddr = a; we = w; dre = r; din = d;
    exp_q.push_back({exp_err, exp_dout});
    cyc = 0;
    stall_cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall) stall_cyc++;
      if (ack) break;
    end
    check("ack_latency", 64'(cyc), 64'(LATENCY + 2));
    check("stall_cycles", 64'(stall_cyc), 64'(LATENCY + 1));
  endtask

  task automatic quiet_window(input string name, input int n);
    int acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check(name, 64'(acks), 64'(0));
  endtask

  // Starts a store, then kills it in the last BUSY cycle by dropping dce or by reset.
  task automatic aborted_store(input logic [31:0] a, input logic [31:0] d, input logic by_reset);
    @(posedge clk); #1;
    dce = 1'b1; daddr = a; we = 4'hF; dre = 4'h0; din = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (by_reset) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dce = 1'b0;
      @(negedge clk);
      check("reset_abort_dout", 64'(dout), 64'(0));
      check("reset_abort_state", 64'(fsm_state), 64'(0));
    end else begin
      dce = 1'b0;
    end
    quiet_window(by_reset ? "no_ack_after_reset_abort" : "no_ack_after_dce_drop", 6);
  endtask

  initial begin
    rst_n = 1'b0; dce = 1'b0; daddr = '0; we = '0; dre = '0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_outputs", {29'd0, ack, stall, err, dout}, 64'd0);
    end

    access(32'h10, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    idle(1);
    access(32'h10, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    idle(1);
    access(32'h10, 4'b1000, 4'h0, 32'hAA000000, 32'h0, 1'b0);
    idle(1);
    access(32'h10, 4'h0, 4'b1000, 32'h0, 32'hAA000000, 1'b0);
    idle(1);
    access(32'h10, 4'h0, 4'hF, 32'h0, 32'hAAADBEEF, 1'b0);
    // dout must hold after the ack cycle
    idle(3);
    @(negedge clk);
    check("dout_hold", 64'(dout), 64'hAAADBEEF);

    // back-to-back: a new request presented in the cycle right after ack
    access(32'h24, 4'hF, 4'h0, 32'h11223344, 32'h0, 1'b0);
    access(32'h24, 4'h0, 4'b0011, 32'h0, 32'h00003344, 1'b0);
    access(32'h10, 4'h0, 4'b0101, 32'h0, 32'h00AD00EF, 1'b0);
    idle(1);

    access(32'h20, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    access(32'h00, 4'hF, 4'h0, 32'h5A5A5A5A, 32'h0, 1'b0);
    idle(1);
    aborted_store(32'h20, 32'h12345678, 1'b0);
    access(32'h20, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    idle(1);
    aborted_store(32'h20, 32'h87654321, 1'b1);
    access(32'h20, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    idle(1);

    // read-before-write on the same access
    access(32'h20, 4'hF, 4'hF, 32'h01020304, 32'hCAFEF00D, 1'b0);
    idle(1);
    access(32'h20, 4'h0, 4'hF, 32'h0, 32'h01020304, 1'b0);
    idle(1);
    // no lanes enabled: full handshake, dout cleared
    access(32'h20, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    idle(1);
    access(32'h20, 4'h0, 4'hF, 32'h0, 32'h01020304, 1'b0);
    idle(1);

    // out of range
    access(32'h8000_0000, 4'hF, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
    idle(1);
    access(32'h0000_1000, 4'hF, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
    idle(1);
    access(32'h00, 4'h0, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0);
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
